// File: rtl/dma_pkg.sv
// Shared definitions for the DMA CSR engine: register map, CTRL/STATUS bit
// positions and the engine state encoding.
package dma_pkg;

  localparam int CH_STRIDE = 32;
  localparam int CH_SHIFT  = $clog2(CH_STRIDE);

  localparam logic [CH_SHIFT-1:0] OFF_SRC    = 5'h00;
  localparam logic [CH_SHIFT-1:0] OFF_DST    = 5'h04;
  localparam logic [CH_SHIFT-1:0] OFF_LEN    = 5'h08;
  localparam logic [CH_SHIFT-1:0] OFF_CTRL   = 5'h0C;
  localparam logic [CH_SHIFT-1:0] OFF_STATUS = 5'h10;

  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_ABORT  = 2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_ABORTED = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    XFER = 2'd2
  } dma_state_e;

endpackage

// File: rtl/dma_rr_arbiter.sv
// Round-robin channel picker: first requester at or after ptr_i, wrapping.
module dma_rr_arbiter #(
  parameter int NUM_CH = 4,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [CH_W-1:0]   ptr_i,
  output logic [CH_W-1:0]   gnt_idx_o,
  output logic              gnt_vld_o
);

  // Scan from the farthest candidate back so the nearest requester wins last.
  always_comb begin
    gnt_vld_o = 1'b0;
    gnt_idx_o = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req_i[(int'(ptr_i) + i) % NUM_CH]) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = CH_W'((int'(ptr_i) + i) % NUM_CH);
      end
    end
  end

endmodule

// File: rtl/dma_csr_engine.sv
// Multi-channel DMA engine: per-channel CSRs on a simple register bus and a
// single IDLE/LOAD/XFER engine that serves busy channels round-robin.
module dma_csr_engine
  import dma_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int NUM_CH = 4,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              err,
  output logic              xfer_valid,
  input  logic              xfer_ready,
  output logic [CH_W-1:0]   xfer_ch,
  output logic [ADDR_W-1:0] xfer_src,
  output logic [ADDR_W-1:0] xfer_dst,
  output logic [NUM_CH-1:0] irq
);

  localparam int BEAT_B = DATA_W / 8;

  dma_state_e        state_q, state_d;
  logic [CH_W-1:0]   act_q, act_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0] csrc_q, csrc_d, cdst_q, cdst_d;
  logic [DATA_W-1:0] crem_q, crem_d;

  logic [ADDR_W-1:0] src_q [NUM_CH];
  logic [ADDR_W-1:0] src_d [NUM_CH];
  logic [ADDR_W-1:0] dst_q [NUM_CH];
  logic [ADDR_W-1:0] dst_d [NUM_CH];
  logic [DATA_W-1:0] len_q [NUM_CH];
  logic [DATA_W-1:0] len_d [NUM_CH];
  logic [NUM_CH-1:0] irqen_q, irqen_d, busy_q, busy_d;
  logic [NUM_CH-1:0] done_q, done_d, abrt_q, abrt_d;

  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d, err_q, err_d;

  logic [ADDR_W-1:0]   ch_full;
  logic [CH_SHIFT-1:0] off;
  logic [CH_W-1:0]     ch;
  logic                off_ok, bad, wr_ok, rd_ok;
  logic [CH_W-1:0]     gnt_idx;
  logic                gnt_vld;
  logic                complete, abort_req;

  // Address decode: channel index above the per-channel window, offset within.
  always_comb begin
    ch_full = addr >> CH_SHIFT;
    off     = addr[CH_SHIFT-1:0];
    ch      = ch_full[CH_W-1:0];
    off_ok  = (off == OFF_SRC) || (off == OFF_DST) || (off == OFF_LEN) ||
              (off == OFF_CTRL) || (off == OFF_STATUS);
    bad     = !off_ok || (ch_full >= ADDR_W'(NUM_CH)) || (wr_en && rd_en);
    wr_ok   = wr_en && !bad;
    rd_ok   = rd_en && !bad;
  end

  dma_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req_i     (busy_q),
    .ptr_i     (ptr_q),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  always_comb begin
    state_d   = state_q;
    act_d     = act_q;
    ptr_d     = ptr_q;
    csrc_d    = csrc_q;
    cdst_d    = cdst_q;
    crem_d    = crem_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    irqen_d   = irqen_q;
    busy_d    = busy_q;
    done_d    = done_q;
    abrt_d    = abrt_q;
    rdata_d   = '0;
    rvalid_d  = rd_en;
    err_d     = (wr_en || rd_en) && bad;
    complete  = 1'b0;
    abort_req = 1'b0;

    if (rd_ok) begin
      case (off)
        OFF_SRC:    rdata_d = DATA_W'(src_q[ch]);
        OFF_DST:    rdata_d = DATA_W'(dst_q[ch]);
        OFF_LEN:    rdata_d = len_q[ch];
        OFF_CTRL:   rdata_d = DATA_W'(irqen_q[ch]) << CTRL_IRQ_EN;
        OFF_STATUS: rdata_d = (DATA_W'(busy_q[ch]) << STAT_BUSY) |
                              (DATA_W'(done_q[ch]) << STAT_DONE) |
                              (DATA_W'(abrt_q[ch]) << STAT_ABORTED);
        default:    rdata_d = '0;
      endcase
    end

    // Transfer parameters are frozen while a channel is busy.
    if (wr_ok) begin
      case (off)
        OFF_SRC: if (!busy_q[ch]) src_d[ch] = ADDR_W'(wdata);
        OFF_DST: if (!busy_q[ch]) dst_d[ch] = ADDR_W'(wdata);
        OFF_LEN: if (!busy_q[ch]) len_d[ch] = wdata;
        OFF_CTRL: begin
          irqen_d[ch] = wdata[CTRL_IRQ_EN];
          if (wdata[CTRL_START] && !busy_q[ch]) busy_d[ch] = 1'b1;
          if (wdata[CTRL_ABORT] && busy_q[ch])  abort_req   = 1'b1;
        end
        OFF_STATUS: begin
          if (wdata[STAT_DONE])    done_d[ch] = 1'b0;
          if (wdata[STAT_ABORTED]) abrt_d[ch] = 1'b0;
        end
        default: ;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          state_d = LOAD;
          act_d   = gnt_idx;
          ptr_d   = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end
      LOAD: begin
        // Channel may have been aborted while it was being granted.
        if (!busy_q[act_q]) begin
          state_d = IDLE;
        end else if (len_q[act_q] == '0) begin
          complete = 1'b1;
          state_d  = IDLE;
        end else begin
          csrc_d  = src_q[act_q];
          cdst_d  = dst_q[act_q];
          crem_d  = len_q[act_q];
          state_d = XFER;
        end
      end
      XFER: begin
        if (xfer_ready) begin
          csrc_d = csrc_q + ADDR_W'(BEAT_B);
          cdst_d = cdst_q + ADDR_W'(BEAT_B);
          crem_d = crem_q - 1'b1;
          if (crem_q == DATA_W'(1)) begin
            complete = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Hardware set happens after the W1C clears so set wins on a collision.
    if (complete) begin
      busy_d[act_q] = 1'b0;
      done_d[act_q] = 1'b1;
    end
    if (abort_req && !(complete && ch == act_q)) begin
      busy_d[ch] = 1'b0;
      abrt_d[ch] = 1'b1;
      if (state_q != IDLE && ch == act_q) state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      act_q    <= '0;
      ptr_q    <= '0;
      csrc_q   <= '0;
      cdst_q   <= '0;
      crem_q   <= '0;
      irqen_q  <= '0;
      busy_q   <= '0;
      done_q   <= '0;
      abrt_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        src_q[c] <= '0;
        dst_q[c] <= '0;
        len_q[c] <= '0;
      end
    end else begin
      state_q  <= state_d;
      act_q    <= act_d;
      ptr_q    <= ptr_d;
      csrc_q   <= csrc_d;
      cdst_q   <= cdst_d;
      crem_q   <= crem_d;
      irqen_q  <= irqen_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      abrt_q   <= abrt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
    end
  end

  assign rdata      = rdata_q;
  assign rvalid     = rvalid_q;
  assign err        = err_q;
  assign xfer_valid = (state_q == XFER);
  assign xfer_ch    = act_q;
  assign xfer_src   = csrc_q;
  assign xfer_dst   = cdst_q;
  assign irq        = done_q & irqen_q;

endmodule

// File: tb/tb_dma_csr_engine.sv
// Directed bench for dma_csr_engine: register access, transfers, arbitration,
// abort, bus errors and reset behaviour.
module tb_dma_csr_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0, rd_en = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        rvalid, err, xfer_valid;
  logic        xfer_ready = 1'b0;
  logic [1:0]  xfer_ch;
  logic [31:0] xfer_src, xfer_dst;
  logic [3:0]  irq;

  int checks = 0;
  int failures = 0;

  logic [1:0]  log_ch[$];
  logic [31:0] log_src[$];
  logic [31:0] log_dst[$];

  dma_csr_engine #(.DATA_W(32), .ADDR_W(32), .NUM_CH(4)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
    .wdata(wdata), .rdata(rdata), .rvalid(rvalid), .err(err),
    .xfer_valid(xfer_valid), .xfer_ready(xfer_ready), .xfer_ch(xfer_ch),
    .xfer_src(xfer_src), .xfer_dst(xfer_dst), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && xfer_valid && xfer_ready) begin
      log_ch.push_back(xfer_ch);
      log_src.push_back(xfer_src);
      log_dst.push_back(xfer_dst);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic v, output logic e);
    addr = a; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    d = rdata; v = rvalid; e = err;
  endtask

  task automatic wait_beats(input int n);
    for (int k = 0; k < 200 && log_ch.size() < n; k++) tick();
  endtask

  task automatic clear_log();
    log_ch.delete(); log_src.delete(); log_dst.delete();
  endtask

  task automatic test_reset();
    logic [31:0] d; logic v, e;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    checks++;
    if ({rdata, rvalid, err, xfer_valid, irq, xfer_ch, xfer_src, xfer_dst} !== '0) begin
      failures++;
      $display("FAIL reset_outputs rdata=%h rvalid=%b err=%b xv=%b irq=%b ch=%0d src=%h dst=%h required all 0",
               rdata, rvalid, err, xfer_valid, irq, xfer_ch, xfer_src, xfer_dst);
    end
    rd(32'h10, d, v, e);
    checks++;
    if (d !== 32'h0 || v !== 1'b1 || e !== 1'b0) begin
      failures++;
      $display("FAIL reset_status got d=%h v=%b e=%b required d=0 v=1 e=0", d, v, e);
    end
    tick();
    checks++;
    if (rvalid !== 1'b0 || rdata !== 32'h0) begin
      failures++;
      $display("FAIL rvalid_pulse got rvalid=%b rdata=%h required 0/0", rvalid, rdata);
    end
  endtask

  task automatic test_basic();
    logic [31:0] d; logic v, e;
    clear_log();
    wr(32'h00, 32'h1000);
    wr(32'h04, 32'h2000);
    wr(32'h08, 32'd3);
    xfer_ready = 1'b1;
    wr(32'h0C, 32'h1);
    wait_beats(3);
    tick();
    checks++;
    if (log_ch.size() != 3) begin
      failures++;
      $display("FAIL basic_count got=%0d required=3", log_ch.size());
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (log_ch[i] !== 2'd0 || log_src[i] !== 32'h1000 + 32'(4 * i) || log_dst[i] !== 32'h2000 + 32'(4 * i)) begin
        failures++;
        $display("FAIL basic_beat%0d got ch=%0d src=%h dst=%h required ch=0 src=%h dst=%h",
                 i, log_ch[i], log_src[i], log_dst[i], 32'h1000 + 32'(4 * i), 32'h2000 + 32'(4 * i));
      end
    end
    checks++;
    if (xfer_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_idle got xfer_valid=%b required 0", xfer_valid);
    end
    rd(32'h10, d, v, e);
    checks++;
    if (d !== 32'h2 || v !== 1'b1) begin
      failures++;
      $display("FAIL basic_status got=%h v=%b required=00000002 v=1", d, v);
    end
    rd(32'h00, d, v, e);
    checks++;
    if (d !== 32'h1000) begin
      failures++;
      $display("FAIL basic_src_readback got=%h required=00001000", d);
    end
    wr(32'h10, 32'h2);
  endtask

  task automatic test_bus_errors();
    logic [31:0] d; logic v, e;
    logic [31:0] bad_addr [2] = '{32'h14, 32'h80};
    for (int i = 0; i < 2; i++) begin
      rd(bad_addr[i], d, v, e);
      checks++;
      if (e !== 1'b1 || v !== 1'b1 || d !== 32'h0) begin
        failures++;
        $display("FAIL bad_read_%h got err=%b rvalid=%b rdata=%h required 1/1/0", bad_addr[i], e, v, d);
      end
      tick();
      checks++;
      if (err !== 1'b0) begin
        failures++;
        $display("FAIL err_pulse_%h got err=%b required 0", bad_addr[i], err);
      end
    end
    addr = 32'h00; wdata = 32'hDEAD; wr_en = 1'b1; rd_en = 1'b1;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    checks++;
    if (err !== 1'b1 || rvalid !== 1'b1 || rdata !== 32'h0) begin
      failures++;
      $display("FAIL wr_rd_both got err=%b rvalid=%b rdata=%h required 1/1/0", err, rvalid, rdata);
    end
    rd(32'h00, d, v, e);
    checks++;
    if (d !== 32'h1000 || e !== 1'b0) begin
      failures++;
      $display("FAIL wr_rd_both_unchanged got src=%h err=%b required 00001000/0", d, e);
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] d; logic v, e;
    int exp_a [4] = '{1, 1, 3, 3};
    int exp_c [6] = '{1, 1, 2, 2, 0, 0};
    for (int c = 0; c < 4; c++) begin
      wr(32'(c * 32) + 32'h00, 32'h100 + 32'(c * 32'h200));
      wr(32'(c * 32) + 32'h04, 32'h200 + 32'(c * 32'h200));
      wr(32'(c * 32) + 32'h08, 32'd2);
    end
    xfer_ready = 1'b0;
    clear_log();
    wr(32'h2C, 32'h1);
    wr(32'h6C, 32'h1);
    xfer_ready = 1'b1;
    wait_beats(4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (log_ch[i] !== exp_a[i][1:0]) begin
        failures++;
        $display("FAIL rr_a_beat%0d got ch=%0d required ch=%0d", i, log_ch[i], exp_a[i]);
      end
    end
    checks++;
    if (log_src[2] !== 32'h700 || log_dst[3] !== 32'h804) begin
      failures++;
      $display("FAIL rr_a_ch3_addr got src=%h dst=%h required 00000700/00000804", log_src[2], log_dst[3]);
    end
    xfer_ready = 1'b0;
    tick();
    clear_log();
    wr(32'h2C, 32'h1);
    wr(32'h4C, 32'h1);
    wr(32'h0C, 32'h1);
    wr(32'h28, 32'd9);
    xfer_ready = 1'b1;
    wait_beats(6);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (log_ch[i] !== exp_c[i][1:0]) begin
        failures++;
        $display("FAIL rr_c_beat%0d got ch=%0d required ch=%0d", i, log_ch[i], exp_c[i]);
      end
    end
    rd(32'h28, d, v, e);
    checks++;
    if (d !== 32'd2 || e !== 1'b0) begin
      failures++;
      $display("FAIL busy_len_write got len=%0d err=%b required 2/0", d, e);
    end
    rd(32'h70, d, v, e);
    checks++;
    if (d !== 32'h2) begin
      failures++;
      $display("FAIL rr_ch3_status got=%h required=00000002", d);
    end
    for (int c = 0; c < 4; c++) wr(32'(c * 32) + 32'h10, 32'h6);
  endtask

  task automatic test_abort();
    logic [31:0] d; logic v, e;
    wr(32'h40, 32'h3000);
    wr(32'h44, 32'h4000);
    wr(32'h48, 32'd5);
    xfer_ready = 1'b0;
    clear_log();
    wr(32'h4C, 32'h3);
    for (int k = 0; k < 60 && log_ch.size() < 2; k++) begin
      xfer_ready = ~xfer_ready;
      tick();
    end
    xfer_ready = 1'b0;
    wr(32'h4C, 32'h6);
    checks++;
    if (xfer_valid !== 1'b0) begin
      failures++;
      $display("FAIL abort_valid_drop got xfer_valid=%b required 0", xfer_valid);
    end
    xfer_ready = 1'b1;
    repeat (10) tick();
    checks++;
    if (log_ch.size() != 2 || log_src[0] !== 32'h3000 || log_src[1] !== 32'h3004 || log_ch[1] !== 2'd2) begin
      failures++;
      $display("FAIL abort_beats got n=%0d src0=%h src1=%h required n=2 00003000/00003004",
               log_ch.size(), log_src[0], log_src[1]);
    end
    rd(32'h50, d, v, e);
    checks++;
    if (d !== 32'h4) begin
      failures++;
      $display("FAIL abort_status got=%h required=00000004", d);
    end
    checks++;
    if (irq[2] !== 1'b0) begin
      failures++;
      $display("FAIL abort_irq got irq=%b required irq[2]=0", irq);
    end
    wr(32'h50, 32'h4);
    wr(32'h4C, 32'h0);
  endtask

  task automatic test_len_zero();
    logic [31:0] d; logic v, e;
    int hv = 0;
    clear_log();
    wr(32'h68, 32'd0);
    wr(32'h6C, 32'h3);
    repeat (6) begin
      tick();
      if (xfer_valid) hv++;
    end
    checks++;
    if (hv != 0 || log_ch.size() != 0) begin
      failures++;
      $display("FAIL len0_no_beats got valid_cycles=%0d beats=%0d required 0/0", hv, log_ch.size());
    end
    rd(32'h70, d, v, e);
    checks++;
    if (d !== 32'h2) begin
      failures++;
      $display("FAIL len0_status got=%h required=00000002", d);
    end
    checks++;
    if (irq !== 4'b1000) begin
      failures++;
      $display("FAIL len0_irq got=%b required=1000", irq);
    end
    wr(32'h70, 32'h2);
    checks++;
    if (irq !== 4'b0000) begin
      failures++;
      $display("FAIL len0_irq_clear got=%b required=0000", irq);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic v, e;
    wr(32'h00, 32'h1000);
    wr(32'h04, 32'h2000);
    wr(32'h08, 32'd4);
    xfer_ready = 1'b1;
    clear_log();
    wr(32'h0C, 32'h3);
    wait_beats(1);
    checks++;
    if (xfer_valid !== 1'b1 || xfer_src !== 32'h1004) begin
      failures++;
      $display("FAIL mid_beat2 got xv=%b src=%h required 1/00001004", xfer_valid, xfer_src);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({rdata, rvalid, err, xfer_valid, irq, xfer_ch, xfer_src, xfer_dst} !== '0) begin
      failures++;
      $display("FAIL mid_reset_outputs xv=%b irq=%b src=%h dst=%h ch=%0d rv=%b required all 0",
               xfer_valid, irq, xfer_src, xfer_dst, xfer_ch, rvalid);
    end
    rst = 1'b0;
    rd(32'h10, d, v, e);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL mid_reset_status got=%h required=00000000", d);
    end
    rd(32'h00, d, v, e);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL mid_reset_src got=%h required=00000000", d);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bus_errors();
    test_round_robin();
    test_abort();
    test_len_zero();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
